// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - port A/B request buses and SDRAM controller side of the arbiter
interface sdram_arbiter_if;
   logic        ram_ready;
   logic        a_req, b_req;
   logic [24:0] a_addr, b_addr;
   logic        a_we, b_we;
   logic [7:0]  a_din, b_din;
   logic [7:0]  a_dout, b_dout;
   logic        a_ack, b_ack;
   logic        mem_cs, mem_we, mem_refresh;
   logic [24:0] mem_addr;
   logic [7:0]  mem_din, mem_dout;

   modport slave (
      input  ram_ready, a_req, b_req, a_addr, b_addr, a_we, b_we, a_din, b_din, mem_dout,
      output a_dout, b_dout, a_ack, b_ack, mem_cs, mem_we, mem_refresh, mem_addr, mem_din
   );

   modport master (
      output ram_ready, a_req, b_req, a_addr, b_addr, a_we, b_we, a_din, b_din, mem_dout,
      input  a_dout, b_dout, a_ack, b_ack, mem_cs, mem_we, mem_refresh, mem_addr, mem_din
   );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port SDRAM arbiter with fixed 8-clock slots and periodic refresh
module sdram_arbiter #(
   parameter int REFRESH_CYCLES = 480
) (
   input logic            clk,
   input logic            reset_n,
   sdram_arbiter_if.slave bus
);
   localparam int            CW     = $clog2(REFRESH_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_REFRESH} state_t;

   state_t        state_q, state_d;
   logic [2:0]    k_q, k_d;
   logic          gnt_b_q, gnt_b_d;
   logic          last_b_q, last_b_d;
   logic          pend_q, pend_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic          mem_cs_q, mem_cs_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_refresh_q, mem_refresh_d;
   logic [24:0]   mem_addr_q, mem_addr_d;
   logic [7:0]    mem_din_q, mem_din_d;
   logic [7:0]    a_dout_q, a_dout_d;
   logic [7:0]    b_dout_q, b_dout_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic          decide, a_ok, b_ok, pick_b, expire, start_ref;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         k_q           <= 3'd0;
         gnt_b_q       <= 1'b0;
         last_b_q      <= 1'b1;
         pend_q        <= 1'b0;
         rcnt_q        <= RELOAD;
         mem_cs_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_refresh_q <= 1'b0;
         mem_addr_q    <= '0;
         mem_din_q     <= '0;
         a_dout_q      <= '0;
         b_dout_q      <= '0;
         a_ack_q       <= 1'b0;
         b_ack_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         gnt_b_q       <= gnt_b_d;
         last_b_q      <= last_b_d;
         pend_q        <= pend_d;
         rcnt_q        <= rcnt_d;
         mem_cs_q      <= mem_cs_d;
         mem_we_q      <= mem_we_d;
         mem_refresh_q <= mem_refresh_d;
         mem_addr_q    <= mem_addr_d;
         mem_din_q     <= mem_din_d;
         a_dout_q      <= a_dout_d;
         b_dout_q      <= b_dout_d;
         a_ack_q       <= a_ack_d;
         b_ack_q       <= b_ack_d;
      end
   end

   always_comb begin
      decide    = (state_q == S_IDLE) || (k_q == 3'd7);
      // A port acking this clock has just been served and sits out one round.
      a_ok      = bus.a_req && !a_ack_q;
      b_ok      = bus.b_req && !b_ack_q;
      pick_b    = b_ok && (!a_ok || !last_b_q);
      expire    = (rcnt_q == '0);
      start_ref = 1'b0;

      state_d       = state_q;
      k_d           = k_q;
      gnt_b_d       = gnt_b_q;
      last_b_d      = last_b_q;
      mem_cs_d      = mem_cs_q;
      mem_we_d      = mem_we_q;
      mem_refresh_d = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_din_d     = mem_din_q;
      a_dout_d      = a_dout_q;
      b_dout_d      = b_dout_q;
      a_ack_d       = 1'b0;
      b_ack_d       = 1'b0;
      rcnt_d        = expire ? RELOAD : rcnt_q - CW'(1);

      if (decide) begin
         state_d    = S_IDLE;
         k_d        = 3'd0;
         mem_cs_d   = 1'b0;
         mem_we_d   = 1'b0;
         mem_addr_d = '0;
         mem_din_d  = '0;
         if (bus.ram_ready && pend_q) begin
            state_d       = S_REFRESH;
            mem_refresh_d = 1'b1;
            start_ref     = 1'b1;
         end else if (bus.ram_ready && (a_ok || b_ok)) begin
            state_d    = S_ACCESS;
            gnt_b_d    = pick_b;
            last_b_d   = pick_b;
            mem_cs_d   = 1'b1;
            mem_we_d   = pick_b ? bus.b_we   : bus.a_we;
            mem_addr_d = pick_b ? bus.b_addr : bus.a_addr;
            mem_din_d  = pick_b ? bus.b_din  : bus.a_din;
         end
      end else begin
         k_d = k_q + 3'd1;
         if (state_q == S_ACCESS) begin
            if (k_q == 3'd5) mem_cs_d = 1'b0;
            if (k_q == 3'd6) begin
               if (gnt_b_q) begin
                  b_ack_d = 1'b1;
                  if (!mem_we_q) b_dout_d = bus.mem_dout;
               end else begin
                  a_ack_d = 1'b1;
                  if (!mem_we_q) a_dout_d = bus.mem_dout;
               end
            end
         end
      end

      // An expiry coinciding with the refresh start must not be lost.
      pend_d = expire || (pend_q && !start_ref);
   end

   assign bus.mem_cs      = mem_cs_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_refresh = mem_refresh_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_din     = mem_din_q;
   assign bus.a_dout      = a_dout_q;
   assign bus.b_dout      = b_dout_q;
   assign bus.a_ack       = a_ack_q;
   assign bus.b_ack       = b_ack_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed vector bench for sdram_arbiter
module tb_sdram_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;

   sdram_arbiter_if bus ();
   sdram_arbiter_if bus2 ();

   sdram_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   sdram_arbiter #(.REFRESH_CYCLES(20)) dut_r (.clk(clk), .reset_n(reset_n), .bus(bus2));

   always #5 clk = ~clk;
   always @(posedge clk) edge_n = reset_n ? edge_n + 1 : 0;

   typedef struct {
      logic        a_req;
      logic        a_we;
      logic [24:0] a_addr;
      logic [7:0]  a_din;
      logic [7:0]  a_rd;
      logic        b_req;
      logic        b_we;
      logic [24:0] b_addr;
      logic [7:0]  b_din;
      logic [7:0]  b_rd;
      logic        first_b;
      logic [7:0]  exp_a_dout;
      logic [7:0]  exp_b_dout;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs1();
      return {10'b0, bus.mem_cs, bus.mem_we, bus.mem_refresh, bus.mem_addr, bus.mem_din,
              bus.a_dout, bus.b_dout, bus.a_ack, bus.b_ack};
   endfunction

   function automatic logic [63:0] outs2();
      return {10'b0, bus2.mem_cs, bus2.mem_we, bus2.mem_refresh, bus2.mem_addr, bus2.mem_din,
              bus2.a_dout, bus2.b_dout, bus2.a_ack, bus2.b_ack};
   endfunction

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Waits for the slot to start, then records the cs/ack shape over k = 0..7.
   task automatic run_slot(input logic pb, input logic [24:0] addr, input logic we,
                           input logic [7:0] din, input logic [7:0] rd, input bit drop,
                           input int rr_k);
      int         lat;
      logic [7:0] cs_p, wa_p, la_p;
      bit         held;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (bus.mem_cs !== 1'b1 && lat < 40);
      chk("grant_latency", 64'(lat), 64'd1);
      cs_p = '0;
      wa_p = '0;
      la_p = '0;
      held = 1'b1;
      bus.mem_dout = rd;
      for (int kk = 0; kk < 8; kk++) begin
         if (kk > 0) @(negedge clk);
         if (kk == rr_k) bus.ram_ready = 1'b0;
         cs_p[kk] = bus.mem_cs;
         wa_p[kk] = pb ? bus.b_ack : bus.a_ack;
         la_p[kk] = pb ? bus.a_ack : bus.b_ack;
         if (bus.mem_addr !== addr || bus.mem_we !== we || bus.mem_din !== din) held = 1'b0;
      end
      chk("mem_cs_shape", 64'(cs_p), 64'h3F);
      chk("winner_ack", 64'(wa_p), 64'h80);
      chk("other_ack", 64'(la_p), 64'h00);
      chk("addr_we_din_held", 64'(held), 64'd1);
      if (drop) begin
         if (pb) bus.b_req = 1'b0;
         else    bus.a_req = 1'b0;
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      bus.a_req  = v.a_req;  bus.a_we = v.a_we;  bus.a_addr = v.a_addr;  bus.a_din = v.a_din;
      bus.b_req  = v.b_req;  bus.b_we = v.b_we;  bus.b_addr = v.b_addr;  bus.b_din = v.b_din;
      if (v.a_req && v.b_req) begin
         if (v.first_b) begin
            run_slot(1'b1, v.b_addr, v.b_we, v.b_din, v.b_rd, 1'b1, -1);
            run_slot(1'b0, v.a_addr, v.a_we, v.a_din, v.a_rd, 1'b1, -1);
         end else begin
            run_slot(1'b0, v.a_addr, v.a_we, v.a_din, v.a_rd, 1'b1, -1);
            run_slot(1'b1, v.b_addr, v.b_we, v.b_din, v.b_rd, 1'b1, -1);
         end
      end else if (v.a_req) begin
         run_slot(1'b0, v.a_addr, v.a_we, v.a_din, v.a_rd, 1'b1, -1);
      end else begin
         run_slot(1'b1, v.b_addr, v.b_we, v.b_din, v.b_rd, 1'b1, -1);
      end
      chk("a_dout", 64'(bus.a_dout), 64'(v.exp_a_dout));
      chk("b_dout", 64'(bus.b_dout), 64'(v.exp_b_dout));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bit saw;
      bit pend_m, prev_ref, rose_ref, rose_cs, prev_cs, bad_width, saw_cs1, overlap;
      int last_rise, n_ref1, n_ref2, n_slot2, bad_int, bad_order, n;

      vecs[0] = '{1'b1, 1'b0, 25'h0012345, 8'h00, 8'hA5, 1'b0, 1'b0, 25'h0000000, 8'h00, 8'h00, 1'b0, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 8'h00, 1'b1, 1'b1, 25'h1FFFFFF, 8'h3C, 8'h00, 1'b1, 8'hA5, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 8'h00, 1'b1, 1'b0, 25'h0000000, 8'h00, 8'h5A, 1'b1, 8'hA5, 8'h5A};
      vecs[3] = '{1'b1, 1'b1, 25'h1000000, 8'hFF, 8'h00, 1'b1, 1'b0, 25'h0ABCDEF, 8'h00, 8'hC3, 1'b0, 8'hA5, 8'hC3};
      vecs[4] = '{1'b1, 1'b0, 25'h1555555, 8'h00, 8'h11, 1'b0, 1'b0, 25'h0000000, 8'h00, 8'h00, 1'b0, 8'h11, 8'hC3};
      vecs[5] = '{1'b1, 1'b1, 25'h0000001, 8'h01, 8'h00, 1'b1, 1'b0, 25'h1FFFFFE, 8'h00, 8'h96, 1'b1, 8'h11, 8'h96};
      vecs[6] = '{1'b1, 1'b0, 25'h1FFFFFF, 8'h00, 8'h00, 1'b0, 1'b0, 25'h0000000, 8'h00, 8'h00, 1'b0, 8'h00, 8'h96};

      bus.ram_ready = 1'b0; bus.mem_dout = 8'h00;
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0;
      bus2.ram_ready = 1'b1; bus2.mem_dout = 8'h00;
      bus2.a_req = 1'b0; bus2.a_we = 1'b0; bus2.a_addr = 25'h0000040; bus2.a_din = '0;
      bus2.b_req = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = '0; bus2.b_din = '0;
      reset_n = 1'b0;
      #1;
      chk("reset_outputs", outs1(), 64'd0);
      chk("reset_outputs_r", outs2(), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Held request while the controller is not ready.
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0012345;
      saw = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.mem_cs || bus.a_ack || bus.b_ack) saw = 1'b1;
      end
      chk("no_slot_while_not_ready", 64'(saw), 64'd0);
      bus.ram_ready = 1'b1;
      run_slot(1'b0, 25'h0012345, 1'b0, 8'h00, 8'h42, 1'b1, -1);
      chk("a_dout_after_ready", 64'(bus.a_dout), 64'h42);

      do_reset();
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Both ports saturating: strict A, B, A, B alternation, slots back to back.
      do_reset();
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0000100; bus.a_din = 8'h00;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 25'h0000200; bus.b_din = 8'h3C;
      run_slot(1'b0, 25'h0000100, 1'b0, 8'h00, 8'h5E, 1'b0, -1);
      run_slot(1'b1, 25'h0000200, 1'b1, 8'h3C, 8'h00, 1'b0, -1);
      run_slot(1'b0, 25'h0000100, 1'b0, 8'h00, 8'h5E, 1'b0, -1);
      run_slot(1'b1, 25'h0000200, 1'b1, 8'h3C, 8'h00, 1'b0, -1);
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      chk("rr_a_dout", 64'(bus.a_dout), 64'h5E);
      chk("rr_b_dout_write_untouched", 64'(bus.b_dout), 64'h00);

      // ram_ready drops mid-slot: slot finishes, then no new slot.
      @(negedge clk);
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h1234567;
      run_slot(1'b0, 25'h1234567, 1'b0, 8'h00, 8'h81, 1'b0, 2);
      chk("a_dout_ready_drop", 64'(bus.a_dout), 64'h81);
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.mem_cs || bus.a_ack) saw = 1'b1;
      end
      chk("idle_after_ready_drop", 64'(saw), 64'd0);
      bus.ram_ready = 1'b1;
      run_slot(1'b0, 25'h1234567, 1'b0, 8'h00, 8'h82, 1'b1, -1);
      chk("a_dout_ready_back", 64'(bus.a_dout), 64'h82);

      // Reset pulse in k = 3 of a write slot.
      do_reset();
      @(negedge clk);
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 25'h0F0F0F0; bus.b_din = 8'h99;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.mem_cs !== 1'b1 && n < 40);
      chk("write_slot_started", 64'(bus.mem_cs), 64'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_mid_slot_outputs", outs1(), 64'd0);
      bus.b_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      saw = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.mem_cs || bus.a_ack || bus.b_ack) saw = 1'b1;
      end
      chk("no_ack_after_abandon", 64'(saw), 64'd0);
      bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 25'h0123456;
      run_slot(1'b0, 25'h0123456, 1'b0, 8'h00, 8'hE7, 1'b1, -1);
      chk("a_dout_after_reset", 64'(bus.a_dout), 64'hE7);

      // Refresh timing on the REFRESH_CYCLES = 20 instance; expiries fall on every 20th edge.
      do_reset();
      pend_m = 1'b0; prev_ref = 1'b0; prev_cs = 1'b0; bad_width = 1'b0; saw_cs1 = 1'b0;
      overlap = 1'b0; last_rise = -1; n_ref1 = 0; n_ref2 = 0; n_slot2 = 0;
      bad_int = 0; bad_order = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (i == 100) bus2.a_req = 1'b1;
         n = edge_n;
         rose_ref = bus2.mem_refresh && !prev_ref;
         rose_cs  = bus2.mem_cs && !prev_cs;
         if (bus2.mem_refresh && prev_ref) bad_width = 1'b1;
         if (bus2.mem_refresh && bus2.mem_cs) overlap = 1'b1;
         if (i < 100 && bus2.mem_cs) saw_cs1 = 1'b1;
         if (rose_ref) begin
            if (!pend_m) bad_order++;
            if (i < 100) begin
               if (last_rise >= 0 && n - last_rise != 20) bad_int++;
               n_ref1++;
               last_rise = n;
            end else begin
               n_ref2++;
            end
         end
         if (rose_cs) begin
            if (pend_m) bad_order++;
            n_slot2++;
         end
         pend_m   = (rose_ref ? 1'b0 : pend_m) | (n % 20 == 0);
         prev_ref = bus2.mem_refresh;
         prev_cs  = bus2.mem_cs;
      end
      bus2.a_req = 1'b0;
      chk("idle_refresh_count", 64'(n_ref1), 64'd4);
      chk("idle_refresh_interval", 64'(bad_int), 64'd0);
      chk("idle_no_cs", 64'(saw_cs1), 64'd0);
      chk("refresh_pulse_width", 64'(bad_width), 64'd0);
      chk("refresh_cs_overlap", 64'(overlap), 64'd0);
      chk("refresh_priority_order", 64'(bad_order), 64'd0);
      chk("busy_refresh_seen", 64'(n_ref2 > 0), 64'd1);
      chk("busy_slots_seen", 64'(n_slot2 > 0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: REFRESH_CYCLES, default 480, clocks between refresh requests (7.8 us at 64 MHz, with margin).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ram_ready  in  1  SDRAM controller initialised; no slot starts while 0.
REQ-005 a_req / b_req  in  1 each  port A (core) / port B (loader) request level.
REQ-006 a_addr / b_addr  in  25 each  byte address.
REQ-007 a_we / b_we  in  1 each  1 = write.
REQ-008 a_din / b_din  in  8 each  write data.
REQ-009 a_dout / b_dout  out  8 each  read data, registered.
REQ-010 a_ack / b_ack  out  1 each  one-clock completion pulse.
REQ-011 mem_cs, mem_we, mem_refresh  out  1 each  to controller cs, we, refresh.
REQ-012 mem_addr  out  25; mem_din  out  8; mem_dout  in  8  controller addr, din, dout.

Function
REQ-013 All outputs registered; states IDLE, ACCESS, REFRESH; 3-bit slot counter k.
REQ-014 Every slot is exactly 8 clocks, k = 0..7, k = 0 in first slot clock.
REQ-015 ACCESS slot: mem_cs = 1 for k = 0..5, 0 for k = 6..7; mem_addr, mem_we, mem_din are latched at grant and held constant for the whole slot.
REQ-016 ACCESS slot: mem_dout captured into granted port's dout at the edge ending k = 6; that port's ack = 1 during k = 7 only.
REQ-017 dout of a port changes only on a read completion of that port; write slots leave it unchanged.
REQ-018 REFRESH slot: mem_refresh = 1 during k = 0 only, mem_cs = 0 throughout.
REQ-019 Arbitration is evaluated on every edge in IDLE and on the edge ending k = 7; the winner's slot starts with k = 0 on the next clock, giving back-to-back slots every 8 clocks with no idle clock between.
REQ-020 Arbitration: no grant if ram_ready = 0. Otherwise refresh_pending has highest priority. Ports follow after it.
REQ-021 Port arbitration: a port whose ack is high this clock is excluded. If exactly one port requests, it wins. If both request, round-robin: the port not granted last wins; last-grant initialises to B, so A wins first.
REQ-022 No winner -> IDLE, all mem_* outputs 0.
REQ-023 Refresh counter: reloads to REFRESH_CYCLES-1, decrements every clock irrespective of state, and reloads when it reaches 0.
REQ-024 Counter reaching 0 sets refresh_pending. Pending is saturating: further expiries while set are lost. Pending clears on the edge that starts a REFRESH slot. Counter expiry and the clear on the same edge -> pending remains 1.
REQ-025 Requester holds req, addr, we, din stable from assertion until its ack. Req still high the clock after ack is a new request.
REQ-026 Latency: req sampled high in IDLE with no competitor -> mem_cs high next clock -> ack 8 clocks after the sampling edge.
REQ-027 ram_ready falling mid-slot: the slot completes normally (ack issued), then IDLE.
REQ-028 Address width: mem_addr = port addr unmodified, all 25 bits. No range checking.

Reset
REQ-029 reset_n low, asynchronously: state IDLE, k = 0, all outputs 0 (mem_*, acks, douts), refresh_pending = 0, refresh counter = REFRESH_CYCLES-1, last-grant = B.
REQ-030 A slot in progress at reset is abandoned with no ack. The first slot after release needs ram_ready = 1.

Verification
REQ-031 ram_ready = 0, a_req = 1 for 100 clocks -> mem_cs never rises, no ack. ram_ready -> 1 -> mem_cs rises next clock.
REQ-032 Read: A reads 0x0012345, model returns 0xA5 at the k = 6 edge -> mem_cs high 6 clocks, a_ack during k = 7, a_dout = 0xA5, b_dout unchanged.
REQ-033 Both ports hold req continuously, B writing 0x3C -> grants alternate A, B, A, B, one slot every 8 clocks. Each ack precedes the next grant, with no duplicate grant.
REQ-034 REFRESH_CYCLES = 20, no port traffic -> mem_refresh single-clock pulse every 20 clocks and mem_cs stays 0. With port A saturating, refresh pending -> the next slot is REFRESH.
REQ-035 reset_n pulsed low at k = 3 of a write slot -> all outputs 0 immediately, no ack. After release, a new request is granted normally.
